// File: rtl/fsm_pattern_tx_pkg.sv
// Shared state encoding for the pattern transmitter and the serial detector benches.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/fsm_pattern_tx_if.sv
// Control/serial bundle between a stimulus source (master) and the transmitter (slave).
interface fsm_pattern_tx_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;
  logic [1:0]       y;

  modport master (
    output start, abort, pattern, reps,
    input  w, w_valid, busy, done, y
  );

  modport slave (
    input  start, abort, pattern, reps,
    output w, w_valid, busy, done, y
  );
endinterface

// File: rtl/fsm_pattern_tx_down_counter.sv
// Loadable down counter that saturates at zero, with a zero flag.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  // count register: load has priority, decrement stops at zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - WIDTH'(1);
    end else begin
      value <= value;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/fsm_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB first, reps times,
// with GAP_CYC idle cycles between repetitions, then pulses done.
module fsm_pattern_tx
  import fsm_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic          clk,
  input  logic          resetn,
  fsm_pattern_tx_if.slave bus
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

  state_t           state, state_next;
  logic [PAT_W-1:0] shreg, pat_r;
  logic             sh_load_new, sh_reload, sh_shift;
  logic             bit_load, bit_en, rep_load, rep_en, gap_load, gap_en;
  logic [BIT_W-1:0] bit_val;
  logic [CNT_W-1:0] rep_val;
  logic [GAP_W-1:0] gap_val;
  logic             bit_zero, rep_zero, gap_zero;
  logic             rep_more;
  logic             unused_cnt;

  down_counter #(.WIDTH(BIT_W)) u_bit_cnt (
    .clk(clk), .resetn(resetn), .load(bit_load), .load_val(BIT_LOAD),
    .en(bit_en), .value(bit_val), .zero(bit_zero)
  );

  down_counter #(.WIDTH(CNT_W)) u_rep_left (
    .clk(clk), .resetn(resetn), .load(rep_load), .load_val(bus.reps),
    .en(rep_en), .value(rep_val), .zero(rep_zero)
  );

  down_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk(clk), .resetn(resetn), .load(gap_load), .load_val(GAP_LOAD),
    .en(gap_en), .value(gap_val), .zero(gap_zero)
  );

  // rep_left counts the repetition currently on the wire, so >1 means another follows
  assign rep_more   = !rep_zero && (rep_val != ONE_REP);
  assign unused_cnt = ^{bit_val, gap_val};

  // next-state and datapath control decode
  always_comb begin
    state_next  = state;
    sh_load_new = 1'b0;
    sh_reload   = 1'b0;
    sh_shift    = 1'b0;
    bit_load    = 1'b0;
    bit_en      = 1'b0;
    rep_load    = 1'b0;
    rep_en      = 1'b0;
    gap_load    = 1'b0;
    gap_en      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.reps != '0) begin
            state_next  = SHIFT;
            sh_load_new = 1'b1;
            bit_load    = 1'b1;
            rep_load    = 1'b1;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (bit_zero) begin
          rep_en = 1'b1;
          if (!rep_more) begin
            state_next = DONE;
          end else if (GAP_CYC > 0) begin
            state_next = GAP;
            gap_load   = 1'b1;
          end else begin
            sh_reload = 1'b1;
            bit_load  = 1'b1;
          end
        end else begin
          sh_shift = 1'b1;
          bit_en   = 1'b1;
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (gap_zero) begin
          state_next = SHIFT;
          sh_reload  = 1'b1;
          bit_load   = 1'b1;
        end else begin
          gap_en = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // state, shift register and latched pattern
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      shreg <= '0;
      pat_r <= '0;
    end else begin
      state <= state_next;
      if (sh_load_new) begin
        shreg <= bus.pattern;
        pat_r <= bus.pattern;
      end else if (sh_reload) begin
        shreg <= pat_r;
      end else if (sh_shift) begin
        shreg <= {shreg[PAT_W-2:0], 1'b0};
      end else begin
        shreg <= shreg;
      end
    end
  end

  assign bus.w       = (state == SHIFT) ? shreg[PAT_W-1] : 1'b0;
  assign bus.w_valid = (state == SHIFT);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.y       = state;

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Bench for fsm_pattern_tx: a frame-level queue model checked every cycle on two
// instances (GAP_CYC=2 and GAP_CYC=0), plus directed literal checks and a two-1s detector loopback.
module tb_fsm_pattern_tx;

  typedef logic [5:0] ent_t;            // {w, w_valid, busy, done, y[1:0]}
  typedef ent_t ent_q_t[$];

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] reps = 4'h0;
  logic       armed = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  ent_q_t     q0, q1;
  ent_t       obs0, obs1, exp0, exp1;
  logic       prev1 = 1'b0;
  logic       z1;

  always #5 clk = ~clk;

  fsm_pattern_tx_if #(.PAT_W(8), .CNT_W(4)) if0 ();
  fsm_pattern_tx_if #(.PAT_W(8), .CNT_W(4)) if1 ();

  assign if0.start = start;   assign if1.start = start;
  assign if0.abort = abort;   assign if1.abort = abort;
  assign if0.pattern = pattern; assign if1.pattern = pattern;
  assign if0.reps = reps;     assign if1.reps = reps;

  fsm_pattern_tx #(.PAT_W(8), .CNT_W(4), .GAP_CYC(2)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  fsm_pattern_tx #(.PAT_W(8), .CNT_W(4), .GAP_CYC(0)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));

  assign obs0 = {if0.w, if0.w_valid, if0.busy, if0.done, if0.y};
  assign obs1 = {if1.w, if1.w_valid, if1.busy, if1.done, if1.y};

  // Mealy "two consecutive 1s" detector fed by the gap-free instance
  always @(posedge clk) prev1 <= resetn ? (if1.w_valid & if1.w) : 1'b0;
  assign z1 = if1.w_valid & if1.w & prev1;

  // Expected per-cycle outputs for a whole frame, straight from the frame rules
  function automatic ent_q_t build(logic [7:0] p, int r, int g);
    ent_q_t q;
    q = {};
    for (int k = 0; k < r; k++) begin
      for (int b = 7; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0, 2'b01});
      if (k < r - 1) for (int j = 0; j < g; j++) q.push_back(6'b001010);
    end
    q.push_back(6'b001111);
    return q;
  endfunction

  // Model: consume one cycle per edge; accept start only when no frame is in flight
  initial forever begin
    @(posedge clk);
    armed = 1'b1;
    cyc++;
    if (!resetn) begin
      q0 = {};
      q1 = {};
    end else if (q0.size() != 0 || q1.size() != 0) begin
      if (abort) begin
        q0 = {};
        q1 = {};
      end else begin
        if (q0.size() != 0) void'(q0.pop_front());
        if (q1.size() != 0) void'(q1.pop_front());
      end
    end else if (start && !abort) begin
      q0 = build(pattern, int'(reps), 2);
      q1 = build(pattern, int'(reps), 0);
    end
  end

  // Per-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    if (armed) begin
      exp0 = (q0.size() != 0) ? q0[0] : 6'b000000;
      exp1 = (q1.size() != 0) ? q1[0] : 6'b000000;
      n_chk += 2;
      if (obs0 !== exp0) begin
        n_fail++;
        $display("FAIL model_gap2 cycle %0d: got %b expected %b", cyc, obs0, exp0);
      end
      if (obs1 !== exp1) begin
        n_fail++;
        $display("FAIL model_gap0 cycle %0d: got %b expected %b", cyc, obs1, exp1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start for one edge; returns at the sample point of cycle 1
  task automatic go(input logic [7:0] p, input logic [3:0] r);
    pattern = p;
    reps = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((if0.busy || if1.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, if0.busy | if1.busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic count_done(input int ncyc, output int nd);
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      nd += int'(if0.done) + int'(if1.done);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0]  bits8;
    logic [15:0] bits16;
    logic [17:0] vmask;
    logic [31:0] zmask;
    int          nd, n;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'b0, obs0}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 8'hA5 once: bits in cycles 1..8, done in 9, idle in 10
    go(8'hA5, 4'd1);
    bits8 = 8'h00; n = 0;
    for (int i = 0; i < 8; i++) begin
      bits8 = {bits8[6:0], if0.w};
      n += int'(if0.w_valid);
      @(negedge clk);
    end
    chk("a5_bits", {24'b0, bits8}, 32'hA5);
    chk("a5_valid_cnt", n, 32'd8);
    chk("a5_done_c9", {31'b0, if0.done}, 32'd1);
    @(negedge clk);
    chk("a5_busy_c10", {30'b0, if0.busy, if0.done}, 32'd0);
    wait_idle();

    // 8'hC3 twice with 2 gap cycles: done in cycle 19
    go(8'hC3, 4'd2);
    bits16 = 16'h0000; vmask = 18'h0; nd = 0;
    for (int c = 1; c <= 18; c++) begin
      vmask = {vmask[16:0], if0.w_valid};
      if (if0.w_valid) bits16 = {bits16[14:0], if0.w};
      nd += int'(if0.done);
      @(negedge clk);
    end
    chk("c3_bits", {16'b0, bits16}, 32'hC3C3);
    chk("c3_valid_mask", {14'b0, vmask}, 32'h3FCFF);
    chk("c3_no_early_done", nd, 32'd0);
    chk("c3_done_c19", {31'b0, if0.done}, 32'd1);
    wait_idle();

    // reps=0: single DONE cycle, no bits
    go(8'hAA, 4'd0);
    chk("reps0_c1", {26'b0, obs0}, 32'b001111);
    @(negedge clk);
    chk("reps0_c2_busy", {31'b0, if0.busy}, 32'd0);
    wait_idle();

    // start with 8'hFF in cycle 4 is ignored
    go(8'hA5, 4'd1);
    bits8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bits8 = {bits8[6:0], if0.w};
      start = (i == 3);
      if (i == 3) pattern = 8'hFF;
      @(negedge clk);
    end
    start = 1'b0;
    chk("restart_ignored_bits", {24'b0, bits8}, 32'hA5);
    chk("restart_done_c9", {31'b0, if0.done}, 32'd1);
    wait_idle();

    // abort in cycle 5
    go(8'h5A, 4'd2);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {26'b0, obs0}, 32'd0);
    count_done(20, nd);
    chk("abort_no_done", nd, 32'd0);

    // reset in cycle 3
    go(8'h96, 4'd3);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("reset_mid_idle", {26'b0, obs1}, 32'd0);
    count_done(20, nd);
    chk("reset_no_done", nd, 32'd0);

    // a fresh start still works
    go(8'h3C, 4'd1);
    bits8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bits8 = {bits8[6:0], if1.w};
      @(negedge clk);
    end
    chk("restart_after_reset", {24'b0, bits8}, 32'h3C);
    wait_idle();

    // abort and start together in IDLE: stays idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", {30'b0, if0.busy, if1.busy}, 32'd0);
    @(negedge clk);

    // maximum reps: 15*8 + 14*2 = 148 frame cycles plus the done cycle
    go(8'h81, 4'hF);
    n = 0; nd = 0;
    while (if0.busy && n < 400) begin
      nd += int'(if0.done);
      n++;
      @(negedge clk);
    end
    chk("max_reps_busy_len", n, 32'd149);
    chk("max_reps_one_done", nd, 32'd1);
    wait_idle();

    // loopback: 01100110 x3, no gaps, two-1s detector fires on cycles 3,7,...,23
    go(8'b01100110, 4'd3);
    zmask = 32'h0;
    for (int c = 1; c <= 30; c++) begin
      if (z1) zmask[c] = 1'b1;
      @(negedge clk);
    end
    chk("loopback_z_cycles", zmask, 32'h00888888);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
